riscv_commit_tracer: RTL
========================

Name: riscv_commit_tracer

Overview:
- Synthesizable retire-trace and run-control monitor for the RV32I cores (single-cycle now, pipelined later).
- Attaches to the core's o_pc_debug / o_insn_vld debug outputs.
- Records the last DEPTH retired PCs in a ring buffer and counts cycles and retired instructions.
- Detects program end (self-loop halt) or timeout and raises o_done. Benches and on-board debug poll this block instead of relying on fixed simulation delays.

Parameters:
- XLEN, 32, PC width.
- DEPTH, 8, ring buffer entries; any value >= 2, not required to be a power of two.
- CNT_W, 32, width of cycle and retire counters.
- HALT_REPEAT, 3, consecutive retires of the same PC that declare halt; must be >= 2.
- MAX_CYCLES, 1000, RUN cycles before timeout.
- STALL_CYCLES, 64, idle cycles before stall; used only with the optional feature.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low.
- i_pc_debug  in  XLEN  PC of the retiring instruction.
- i_insn_vld  in  1  an instruction retires this cycle.
- i_clear  in  1  synchronous restart of trace and counters.
- i_rd_idx  in  $clog2(DEPTH)  readout index; 0 = most recent retire.
- o_rd_pc  out  XLEN  registered readout PC.
- o_rd_vld  out  1  readout entry exists.
- o_count  out  $clog2(DEPTH+1)  number of valid entries.
- o_cycle_cnt  out  CNT_W  cycles spent in RUN.
- o_retire_cnt  out  CNT_W  retired instructions.
- o_status  out  2  00 RUN, 01 HALT, 10 TIMEOUT, 11 STALL.
- o_done  out  1  status != RUN.

Behaviour:
- Reset (i_reset=0): state RUN. All counters, wr_ptr, last_pc, repeat_cnt and idle_cnt are 0. All outputs are 0. Buffer contents are don't-care.
- i_clear=1 has the same effect as reset, applied synchronously. It has priority over every other event in the same cycle; the retire sampled in that cycle is discarded.
- State machine, RUN to HALT / TIMEOUT / STALL:
  - RUN to HALT / TIMEOUT / STALL transitions are evaluated every cycle.
  - HALT, TIMEOUT and STALL are terminal. Only i_clear or reset leave them.
- In RUN, every cycle:
  - cycle_cnt increments, saturating at all-ones.
  - If i_insn_vld=1:
    - buf[wr_ptr] <= i_pc_debug.
    - wr_ptr advances and wraps from DEPTH-1 to 0.
    - count increments, saturating at DEPTH; the oldest entry is overwritten silently.
    - retire_cnt increments, saturating.
- Halt detection:
  - On a valid retire: if count>0 and pc==last_pc, repeat_cnt increments; otherwise repeat_cnt=1.
  - last_pc <= pc.
  - When the updated repeat_cnt equals HALT_REPEAT, the next state is HALT. The triggering retire is recorded and counted.
  - Cycles with i_insn_vld=0 do not reset repeat_cnt.
- Timeout: when the updated cycle_cnt equals MAX_CYCLES and halt is not triggering in the same cycle, the next state is TIMEOUT. Halt has priority over timeout, and timeout has priority over stall.
- In terminal states: the buffer, the counters and o_status are frozen, and i_insn_vld is ignored.
- Readout:
  - o_rd_pc and o_rd_vld are registered, 1-cycle latency from i_rd_idx. Readout works in every state.
  - The addressed entry is buf[(wr_ptr-1-i_rd_idx) mod DEPTH], using wr_ptr as it is at sampling time. Modulo arithmetic must be correct for non-power-of-two DEPTH.
  - If i_rd_idx >= count: o_rd_pc=0 and o_rd_vld=0.
  - A same-cycle write is not visible until the next cycle; there is no bypass.
- o_count, o_cycle_cnt, o_retire_cnt and o_status come directly from registers. o_done is combinational from o_status.

Optional Feature:
- Macro: TRACER_STALL_DETECT_EN.
- With it defined:
  - idle_cnt counts consecutive RUN cycles with i_insn_vld=0 and clears on any valid retire.
  - When the updated idle_cnt equals STALL_CYCLES, the next state is STALL (11), unless halt or timeout fires in the same cycle.
- Without it: idle_cnt logic is absent, status 11 is unreachable, and STALL_CYCLES is unused.

Decomposition:
- Package riscv_tracer_pkg:
  - status enum typedef tracer_status_e {ST_RUN=2'b00, ST_HALT=2'b01, ST_TIMEOUT=2'b10, ST_STALL=2'b11}.
  - localparam helpers for pointer and count widths.
- Sub-module tracer_ring_buf:
  - Contains the storage array, wr_ptr wrap logic, count saturation and the registered index-to-slot read mux.
  - Ports: write enable, write data, clear, read index, read data, read valid, count.
- Top level keeps the FSM, counters and halt / timeout / stall detection.

Test Plan:
All scenarios use DEPTH=4, HALT_REPEAT=3, MAX_CYCLES=20 and STALL_CYCLES=5 unless stated otherwise.
1. Reset held low 3 cycles, then released with no retires -> all outputs 0 and o_status=00; after 20 cycles o_status=10, o_done=1, o_cycle_cnt=20.
2. Retire PCs 0x00,0x04,0x08,0x0C,0x10,0x14 on consecutive cycles -> o_count=4, o_retire_cnt=6. Index 0 reads 0x14 and index 3 reads 0x08, each one cycle after the index is applied.
3. Retire 0x40, 0x40, idle cycle, 0x40 -> o_status=01 after the third retire, o_retire_cnt=3; later retires are ignored and counts stay frozen.
4. Halt retire on cycle 20 -> o_status=01, not 10. i_clear asserted alongside a retire -> that retire is dropped and o_count=0 on the next cycle.
5. DEPTH=3 build, 5 retires 1..5 -> indices 0/1/2 read 5/4/3; with o_count=1, index 2 gives o_rd_vld=0 and o_rd_pc=0.
6. With TRACER_STALL_DETECT_EN, 2 retires then 5 idle cycles -> o_status=11. Without the macro, the same stimulus stays at 00 until timeout gives 10.

Source files
------------

// File: rtl/riscv_tracer_pkg.sv
// Shared types and width helpers for the RV32I commit tracer.
// Status encoding matches the o_status output bits directly.
package riscv_tracer_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_STALL   = 2'b11
  } tracer_status_e;

  localparam int STATUS_W = 2;

  // Slot pointer width; a one-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int limit_w(input int limit);
    return (limit > 1) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/tracer_ring_buf.sv
// Ring buffer of retired PCs with a registered, newest-first readout.
// DEPTH need not be a power of two; the slot arithmetic wraps explicitly.
module tracer_ring_buf
  import riscv_tracer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          clear,
  input  logic [ptr_w(DEPTH)-1:0]       rd_idx,
  output logic [XLEN-1:0]               rd_data,
  output logic                          rd_vld,
  output logic [count_w(DEPTH)-1:0]     count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam int SW = PW + 2;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  logic            hit;
  logic [SW-1:0]   sum;
  logic [SW-1:0]   slot_full;
  logic [PW-1:0]   slot;
  logic [1:0]      unused_slot_hi;

  // For any index below count, wr_ptr + DEPTH - 1 - idx lies in [0, 2*DEPTH-2],
  // so one conditional subtract gives the modulo. Out-of-range indices are masked.
  always_comb begin
    hit       = (CW'(rd_idx) < cnt);
    sum       = {2'b00, wr_ptr} + SW'(DEPTH - 1) - {2'b00, rd_idx};
    slot_full = (sum >= SW'(DEPTH)) ? (sum - SW'(DEPTH)) : sum;
    slot      = hit ? slot_full[PW-1:0] : '0;
  end

  assign unused_slot_hi = slot_full[SW-1:PW];

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      cnt     <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      cnt     <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_data <= hit ? mem[slot] : '0;
      rd_vld  <= hit;
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (cnt != CW'(DEPTH)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign count = cnt;

endmodule

// File: rtl/riscv_commit_tracer.sv
// Retire-trace and run-control monitor: PC history, cycle/retire counters,
// halt/timeout detection. Optional stall detection: TRACER_STALL_DETECT_EN.
module riscv_commit_tracer
  import riscv_tracer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int HALT_REPEAT  = 3,
  parameter int MAX_CYCLES   = 1000,
  parameter int STALL_CYCLES = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [XLEN-1:0]              i_pc_debug,
  input  logic                         i_insn_vld,
  input  logic                         i_clear,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_idx,
  output logic [XLEN-1:0]              o_rd_pc,
  output logic                         o_rd_vld,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [CNT_W-1:0]             o_cycle_cnt,
  output logic [CNT_W-1:0]             o_retire_cnt,
  output logic [STATUS_W-1:0]          o_status,
  output logic                         o_done
);

  localparam int RW = limit_w(HALT_REPEAT);

  tracer_status_e   state, state_nxt;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt, cycle_inc;
  logic [XLEN-1:0]  last_pc;
  logic [RW-1:0]    repeat_cnt, repeat_nxt;
  logic             run, retire;
  logic             halt_hit, timeout_hit, stall_hit;
  logic [count_w(DEPTH)-1:0] count;

  assign run    = (state == ST_RUN);
  assign retire = run & i_insn_vld;

  // Detection looks at the values the counters take after this cycle's update.
  always_comb begin
    cycle_inc   = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
    repeat_nxt  = ((count != '0) && (i_pc_debug == last_pc)) ? repeat_cnt + 1'b1 : RW'(1);
    halt_hit    = retire && (repeat_nxt == RW'(HALT_REPEAT));
    timeout_hit = run && (cycle_inc == CNT_W'(MAX_CYCLES));
  end

`ifdef TRACER_STALL_DETECT_EN
  localparam int IW = limit_w(STALL_CYCLES);
  logic [IW-1:0] idle_cnt, idle_nxt;

  always_comb begin
    idle_nxt  = i_insn_vld ? '0 : idle_cnt + 1'b1;
    stall_hit = run && !i_insn_vld && (idle_nxt == IW'(STALL_CYCLES));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idle_cnt <= '0;
    end else if (i_clear) begin
      idle_cnt <= '0;
    end else if (run) begin
      idle_cnt <= idle_nxt;
    end
  end
`else
  localparam int unused_stall_cycles = STALL_CYCLES;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (run) begin
      if (halt_hit) begin
        state_nxt = ST_HALT;
      end else if (timeout_hit) begin
        state_nxt = ST_TIMEOUT;
      end else if (stall_hit) begin
        state_nxt = ST_STALL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_RUN;
    end else if (i_clear) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      last_pc    <= '0;
      repeat_cnt <= '0;
    end else if (i_clear) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      last_pc    <= '0;
      repeat_cnt <= '0;
    end else if (run) begin
      cycle_cnt <= cycle_inc;
      if (i_insn_vld) begin
        if (retire_cnt != '1) begin
          retire_cnt <= retire_cnt + 1'b1;
        end
        last_pc    <= i_pc_debug;
        repeat_cnt <= repeat_nxt;
      end
    end
  end

  // The clear-cycle retire is dropped: the buffer sees clear and no write.
  tracer_ring_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .wr_en   (retire & ~i_clear),
    .wr_data (i_pc_debug),
    .clear   (i_clear),
    .rd_idx  (i_rd_idx),
    .rd_data (o_rd_pc),
    .rd_vld  (o_rd_vld),
    .count   (count)
  );

  assign o_count      = count;
  assign o_cycle_cnt  = cycle_cnt;
  assign o_retire_cnt = retire_cnt;
  assign o_status     = state;
  assign o_done       = (state != ST_RUN);

endmodule
